// File: rtl/x86_gpr_file16_if.sv
// Bus between decode/execute and the 8086 general-purpose register file:
// read ports, the two write ports, the SP adjust strobes and the SP tap.
interface x86_gpr_file16_if #(
    parameter int NUM_RD = 3
);
    logic [3*NUM_RD-1:0]  rd_addr;
    logic [NUM_RD-1:0]    rd_w;
    logic [16*NUM_RD-1:0] rd_data;

    logic                 wr0_en;
    logic                 wr0_w;
    logic [2:0]           wr0_addr;
    logic [15:0]          wr0_data;

    logic                 wr1_en;
    logic                 wr1_w;
    logic [2:0]           wr1_addr;
    logic [15:0]          wr1_data;

    logic                 sp_inc;
    logic                 sp_dec;
    logic [15:0]          sp_q;

    modport master (
        output rd_addr, rd_w,
        output wr0_en, wr0_w, wr0_addr, wr0_data,
        output wr1_en, wr1_w, wr1_addr, wr1_data,
        output sp_inc, sp_dec,
        input  rd_data, sp_q
    );

    modport slave (
        input  rd_addr, rd_w,
        input  wr0_en, wr0_w, wr0_addr, wr0_data,
        input  wr1_en, wr1_w, wr1_addr, wr1_data,
        input  sp_inc, sp_dec,
        output rd_data, sp_q
    );
endinterface

// File: rtl/x86_gpr_file16.sv
// 8086 general-purpose register file: eight 16-bit registers in encoding
// order (AX CX DX BX SP BP SI DI) with AL..BH byte-lane access, NUM_RD read
// ports, two prioritised write ports (wr0 beats wr1), an SP +/-2 adjust and
// optional next-state bypass on the read ports.
module x86_gpr_file16 #(
    parameter int          NUM_RD   = 3,
    parameter bit          BYPASS   = 1'b1,
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic             clk,
    input  logic             rst,
    x86_gpr_file16_if.slave  io_bus
);

    localparam logic [2:0] SP_IDX = 3'd4;

    logic [7:0][15:0] r_regs;
    logic [7:0][15:0] w_next;
    logic [7:0][15:0] w_rd_src;

    // Value a register takes when reset is active.
    function automatic logic [15:0] reset_value(input logic [2:0] idx);
        logic [15:0] res;
        if (idx == SP_IDX) begin
            res = SP_RESET;
        end else begin
            res = 16'h0000;
        end
        return res;
    endfunction

    // Overlay one write port onto a register value. Byte addresses 0..3 hit
    // the low lane of registers 0..3, byte addresses 4..7 their high lane.
    function automatic logic [15:0] lane_write(
        input logic [15:0] cur,
        input logic [2:0]  idx,
        input logic        en,
        input logic        w,
        input logic [2:0]  addr,
        input logic [15:0] data
    );
        logic [15:0] res;
        res = cur;
        if (!en) begin
            res = cur;
        end else if (w) begin
            if (addr == idx) begin
                res = data;
            end else begin
                res = cur;
            end
        end else if ((idx[2] == 1'b0) && (addr[1:0] == idx[1:0])) begin
            if (addr[2]) begin
                res = {data[7:0], cur[7:0]};
            end else begin
                res = {cur[15:8], data[7:0]};
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Extract a word or a zero-extended byte lane from a register set.
    function automatic logic [15:0] read_lane(
        input logic [7:0][15:0] regs,
        input logic [2:0]       addr,
        input logic             w
    );
        logic [15:0] sel;
        logic [15:0] res;
        sel = regs[{1'b0, addr[1:0]}];
        if (w) begin
            res = regs[addr];
        end else if (addr[2]) begin
            res = {8'h00, sel[15:8]};
        end else begin
            res = {8'h00, sel[7:0]};
        end
        return res;
    endfunction

    // Next-state: current -> SP adjust -> wr1 lanes -> wr0 lanes; reset wins.
    always_comb begin
        w_next = r_regs;
        for (int i = 0; i < 8; i++) begin
            if (!rst) begin
                w_next[i] = reset_value(3'(i));
            end else begin
                if (3'(i) == SP_IDX) begin
                    case ({io_bus.sp_inc, io_bus.sp_dec})
                        2'b10:   w_next[i] = r_regs[i] + 16'd2;
                        2'b01:   w_next[i] = r_regs[i] - 16'd2;
                        default: w_next[i] = r_regs[i];
                    endcase
                end else begin
                    w_next[i] = r_regs[i];
                end
                w_next[i] = lane_write(w_next[i], 3'(i), io_bus.wr1_en,
                                       io_bus.wr1_w, io_bus.wr1_addr, io_bus.wr1_data);
                w_next[i] = lane_write(w_next[i], 3'(i), io_bus.wr0_en,
                                       io_bus.wr0_w, io_bus.wr0_addr, io_bus.wr0_data);
            end
        end
    end

    // Register state update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= reset_value(3'(i));
            end
        end else begin
            r_regs <= w_next;
        end
    end

    // Bypass selects whether reads see this cycle's writes before the edge.
    assign w_rd_src = BYPASS ? w_next : r_regs;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign io_bus.rd_data[16*g +: 16] =
            read_lane(w_rd_src, io_bus.rd_addr[3*g +: 3], io_bus.rd_w[g]);
    end

    // SP tap comes straight from the stored register, never bypassed.
    assign io_bus.sp_q = r_regs[SP_IDX];

endmodule

// File: tb/tb_x86_gpr_file16.sv
// Directed bench for x86_gpr_file16: one bypassing instance (3 read ports)
// and one non-bypassing instance (1 read port) sharing write stimulus.
module tb_x86_gpr_file16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    x86_gpr_file16_if #(.NUM_RD(3)) if0 ();
    x86_gpr_file16_if #(.NUM_RD(1)) if1 ();

    x86_gpr_file16 #(.NUM_RD(3), .BYPASS(1'b1), .SP_RESET(16'hFFFE)) u_byp (
        .clk    (clk),
        .rst    (rst),
        .io_bus (if0.slave)
    );

    x86_gpr_file16 #(.NUM_RD(1), .BYPASS(1'b0), .SP_RESET(16'hFFFE)) u_nobyp (
        .clk    (clk),
        .rst    (rst),
        .io_bus (if1.slave)
    );

    // Non-bypass instance mirrors all stimulus of the bypass instance.
    assign if1.rd_addr  = if0.rd_addr[2:0];
    assign if1.rd_w     = if0.rd_w[0];
    assign if1.wr0_en   = if0.wr0_en;
    assign if1.wr0_w    = if0.wr0_w;
    assign if1.wr0_addr = if0.wr0_addr;
    assign if1.wr0_data = if0.wr0_data;
    assign if1.wr1_en   = if0.wr1_en;
    assign if1.wr1_w    = if0.wr1_w;
    assign if1.wr1_addr = if0.wr1_addr;
    assign if1.wr1_data = if0.wr1_data;
    assign if1.sp_inc   = if0.sp_inc;
    assign if1.sp_dec   = if0.sp_dec;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        if0.wr0_en = 1'b0; if0.wr0_w = 1'b0; if0.wr0_addr = 3'd0; if0.wr0_data = 16'h0000;
        if0.wr1_en = 1'b0; if0.wr1_w = 1'b0; if0.wr1_addr = 3'd0; if0.wr1_data = 16'h0000;
        if0.sp_inc = 1'b0; if0.sp_dec = 1'b0;
    endtask

    task automatic wr0(input logic w, input logic [2:0] a, input logic [15:0] d);
        if0.wr0_en = 1'b1; if0.wr0_w = w; if0.wr0_addr = a; if0.wr0_data = d;
    endtask

    task automatic wr1(input logic w, input logic [2:0] a, input logic [15:0] d);
        if0.wr1_en = 1'b1; if0.wr1_w = w; if0.wr1_addr = a; if0.wr1_data = d;
    endtask

    task automatic set_rd(input int p, input logic [2:0] a, input logic w);
        if0.rd_addr[3*p +: 3] = a;
        if0.rd_w[p] = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        if0.rd_addr = '0;
        if0.rd_w = '0;
        idle();

        // Reset edge, then read every word on both instances.
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_rd(0, 3'(i), 1'b1);
            #1;
            check16($sformatf("rst_byp_r%0d", i), if0.rd_data[15:0],
                    (i == 4) ? 16'hFFFE : 16'h0000);
            check16($sformatf("rst_nob_r%0d", i), if1.rd_data,
                    (i == 4) ? 16'hFFFE : 16'h0000);
        end
        check16("rst_sp_q", if0.sp_q, 16'hFFFE);

        // Byte lanes on AX.
        wr0(1'b1, 3'd0, 16'h1234); tick();
        idle(); wr0(1'b0, 3'd4, 16'h99AB); tick();
        idle(); wr0(1'b0, 3'd0, 16'h77CD); tick();
        idle();
        set_rd(0, 3'd0, 1'b1);
        set_rd(1, 3'd4, 1'b0);
        set_rd(2, 3'd0, 1'b0);
        #1;
        check16("ax_word", if0.rd_data[15:0], 16'hABCD);
        check16("ah_byte", if0.rd_data[31:16], 16'h00AB);
        check16("al_byte", if0.rd_data[47:32], 16'h00CD);
        check16("ax_nob", if1.rd_data, 16'hABCD);

        // Dual-write collision on BX, then disjoint lanes of CX.
        wr0(1'b1, 3'd3, 16'h1111);
        wr1(1'b1, 3'd3, 16'h2222);
        tick();
        idle();
        wr0(1'b0, 3'd1, 16'hEE55);
        wr1(1'b0, 3'd5, 16'hFF66);
        tick();
        idle();
        set_rd(0, 3'd3, 1'b1);
        set_rd(1, 3'd1, 1'b1);
        set_rd(2, 3'd5, 1'b0);
        #1;
        check16("bx_wr0_wins", if0.rd_data[15:0], 16'h1111);
        check16("cx_lanes", if0.rd_data[31:16], 16'h6655);
        check16("ch_byte", if0.rd_data[47:32], 16'h0066);

        // SP adjust with wrap, simultaneous strobes, and write override.
        set_rd(0, 3'd4, 1'b1);
        if0.sp_inc = 1'b1;
        #1;
        check16("sp_inc_bypass", if0.rd_data[15:0], 16'h0000);
        check16("sp_q_pre_edge", if0.sp_q, 16'hFFFE);
        tick();
        check16("sp_inc_wrap", if0.sp_q, 16'h0000);
        idle(); if0.sp_dec = 1'b1; tick();
        check16("sp_dec_wrap", if0.sp_q, 16'hFFFE);
        idle(); if0.sp_inc = 1'b1; if0.sp_dec = 1'b1; tick();
        check16("sp_both", if0.sp_q, 16'hFFFE);
        idle(); if0.sp_dec = 1'b1; wr1(1'b1, 3'd4, 16'h0100); tick();
        check16("sp_wr1_over", if0.sp_q, 16'h0100);
        idle(); if0.sp_inc = 1'b1; wr0(1'b1, 3'd4, 16'h0200); tick();
        idle();
        #1;
        check16("sp_wr0_over", if0.sp_q, 16'h0200);
        check16("sp_word_read", if0.rd_data[15:0], 16'h0200);

        // Bypass versus stored-value read of a same-cycle write.
        wr0(1'b1, 3'd6, 16'hBEEF);
        set_rd(0, 3'd6, 1'b1);
        #1;
        check16("si_bypass_pre", if0.rd_data[15:0], 16'hBEEF);
        check16("si_nobyp_pre", if1.rd_data, 16'h0000);
        tick();
        idle();
        #1;
        check16("si_nobyp_post", if1.rd_data, 16'hBEEF);
        check16("si_bypass_post", if0.rd_data[15:0], 16'hBEEF);

        // Reset mid-operation discards that edge's write and adjust.
        wr0(1'b1, 3'd7, 16'h7777);
        if0.sp_dec = 1'b1;
        rst = 1'b0;
        set_rd(0, 3'd7, 1'b1);
        set_rd(1, 3'd4, 1'b1);
        #1;
        check16("di_rst_bypass", if0.rd_data[15:0], 16'h0000);
        check16("sp_rst_bypass", if0.rd_data[31:16], 16'hFFFE);
        tick();
        rst = 1'b1;
        idle();
        #1;
        check16("di_after_rst", if0.rd_data[15:0], 16'h0000);
        check16("sp_after_rst", if0.rd_data[31:16], 16'hFFFE);
        check16("sp_q_after_rst", if0.sp_q, 16'hFFFE);
        check16("di_nob_after_rst", if1.rd_data, 16'h0000);
        set_rd(2, 3'd0, 1'b1);
        #1;
        check16("ax_after_rst", if0.rd_data[47:32], 16'h0000);

        // Operation resumes on the first edge with reset released.
        wr0(1'b1, 3'd7, 16'h1357);
        tick();
        idle();
        #1;
        check16("di_resume", if0.rd_data[15:0], 16'h1357);
        check16("di_resume_nob", if1.rd_data, 16'h1357);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/x86_gpr_file16.md
# x86_gpr_file16

Parametrised 16-bit general-purpose register file for the 8086 core: eight word registers in 8086 encoding order (AX, CX, DX, BX, SP, BP, SI, DI) with byte-lane access to AL..BH. It has a configurable number of read ports, two write ports with fixed priority, a dedicated stack-pointer adjust port and optional write-to-read bypass. It sits between decode and the ALU/memory stages, replacing the 8-bit, 4-register file.

## Interface
- NUM_RD, default 3: number of read ports, legal range 1..4.
- BYPASS, default 1: 1 = reads return the register's next-state value; 0 = reads return the current stored value.
- SP_RESET, default 16'hFFFE: value SP takes on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- rd_addr  in  3*NUM_RD  read address per port; port i uses [3i+2:3i].
- rd_w  in  NUM_RD  per-port width: 1 = word, 0 = byte.
- rd_data  out  16*NUM_RD  read data per port; port i uses [16i+15:16i].
- wr0_en, wr1_en  in  1 each  write enables; port 0 carries ALU results, port 1 carries memory loads.
- wr0_w, wr1_w  in  1 each  write width: 1 = word, 0 = byte.
- wr0_addr, wr1_addr  in  3 each  write addresses.
- wr0_data, wr1_data  in  16 each  write data; byte writes use [7:0] only.
- sp_inc, sp_dec  in  1 each  SP += 2 (pop) / SP -= 2 (push).
- sp_q  out  16  current stored SP, registered.

## Operation
- Word addressing (w=1): addr n selects register n, 0..7 = AX, CX, DX, BX, SP, BP, SI, DI.
- Byte addressing (w=0):
  - addr 0..3 selects the low byte of registers 0..3 (AL, CL, DL, BL).
  - addr 4..7 selects the high byte of registers 0..3 (AH, CH, DH, BH).
- Byte reads are zero-extended to 16 bits.
- Byte writes modify only the addressed lane. The other lane holds its value.
- Next-state computation per register, in this order:
  1. Start from the current value.
  2. Apply the SP adjust (SP only).
  3. Apply wr1 lane writes.
  4. Apply wr0 lane writes.
- Consequences of the ordering:
  - wr0 beats wr1 on any lane both ports write.
  - Disjoint lanes of the same register (e.g. wr0 to AL, wr1 to AH) both take effect.
  - Any write port touching an SP lane overrides the adjust on that lane. The adjusted value survives only on lanes that no port writes.
- SP adjust:
  - sp_inc alone: SP + 2, modulo 2^16.
  - sp_dec alone: SP − 2, modulo 2^16.
  - Both set, or neither set: no adjust.
- Reset (rst=0 at an edge):
  - All registers go to 0, except SP which goes to SP_RESET.
  - Reset overrides all writes and adjusts in that cycle.
- Read data is combinational from addresses:
  - BYPASS=1: rd_data = lane(s) of the next-state value. During an active reset cycle this is the reset value.
  - BYPASS=0: rd_data = lane(s) of the stored value.
- Multiple read ports may address the same register. Each port is independent.

## Timing
- Write latency is one edge: data present with wrX_en at edge k is stored after edge k.
- Read latency:
  - BYPASS=0: zero cycles from the address; reflects writes from edge k onward, starting in cycle k+1.
  - BYPASS=1: the same-cycle write is visible before the edge.
- sp_q is registered and reflects state after each edge; it is never bypassed.
- Reset values after the reset edge:
  - sp_q = SP_RESET.
  - All rd_data = 0, except reads of SP, which return SP_RESET (word) or the matching byte of it.
- Reset asserted mid-burst discards pending writes and adjusts of that edge. Operation resumes on the first edge with rst=1.
- Before the first reset edge, contents are undefined. The bench must reset first.
- No stalls or handshakes: every enabled write commits at its edge.

## Test plan
- Reset: rst=0 for one edge, then read all 8 words.
  - Required: AX..BP..DI = 16'h0000, SP = 16'hFFFE, sp_q = 16'hFFFE.
- Byte lanes:
  - Word-write AX=16'h1234.
  - Byte-write addr4 (AH) = 8'hAB, then addr0 (AL) = 8'hCD.
  - Required: word read AX = 16'hABCD; byte read addr4 = 16'h00AB.
- Dual-write collision, same edge:
  - wr0 word BX = 16'h1111 and wr1 word BX = 16'h2222 → BX = 16'h1111.
  - Next edge, wr0 byte CL = 8'h55 and wr1 byte CH = 8'h66 → CX = 16'h6655.
- SP adjust and wrap:
  - From SP = 16'hFFFE, sp_inc → 16'h0000; sp_dec → 16'hFFFE.
  - sp_inc and sp_dec together → unchanged.
  - sp_dec with wr1 word SP = 16'h0100 → 16'h0100.
  - sp_dec with wr0 byte write to SP's low lane is not expressible. Instead check wr0 word SP = 16'h0200 with sp_inc → 16'h0200.
- Bypass, BYPASS=1:
  - Same cycle as wr0 word SI = 16'hBEEF, rd_addr0 = 6 word → rd_data0 = 16'hBEEF before the edge.
  - Repeat with BYPASS=0 → old value 16'h0000 before the edge, 16'hBEEF after.
- Reset mid-operation:
  - Assert rst=0 on the same edge as wr0 word DI = 16'h7777 and sp_dec.
  - Required: DI = 16'h0000 and SP = 16'hFFFE after the edge.
